// File: rtl/mcycle_arbiter.sv
// mcycle_arbiter: shares one multi-cycle multiply/divide unit between two
// requesters with round-robin arbitration. Operands/op are latched on grant,
// Start is pulsed once, results are captured when the unit drops Busy and
// handed back to the owner with a one-cycle Ack.
// Optional result reuse: define MCYCLE_REUSE_EN to skip the unit when a
// granted request repeats the last computed op/operands.
//
// state | meaning
// IDLE  | no owner; arbitrate between Req0/Req1
// ISSUE | Start pulse to the unit with the latched op/operands
// WAIT  | unit running; capture results once UnitBusy is low
// RESP  | Ack to the owner, results valid
module mcycle_arbiter #(
  parameter int width = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Req0_i,
  input  logic             Req1_i,
  input  logic             Op0_i,
  input  logic             Op1_i,
  input  logic [width-1:0] A0_i,
  input  logic [width-1:0] B0_i,
  input  logic [width-1:0] A1_i,
  input  logic [width-1:0] B1_i,
  output logic             Ack0_o,
  output logic             Ack1_o,
  output logic [width-1:0] Result1_o,
  output logic [width-1:0] Result2_o,
  output logic             Grant_o,
  output logic             ArbBusy_o,
  output logic             Start_o,
  output logic             MCycleOp_o,
  output logic [width-1:0] Operand1_o,
  output logic [width-1:0] Operand2_o,
  input  logic             UnitBusy_i,
  input  logic [width-1:0] UnitResult1_i,
  input  logic [width-1:0] UnitResult2_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             prio_q, prio_d;
  logic             start_q, start_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             op_q, op_d;
  logic [width-1:0] opa_q, opa_d;
  logic [width-1:0] opb_q, opb_d;
  logic [width-1:0] res1_q, res1_d;
  logic [width-1:0] res2_q, res2_d;

  logic             any_req;
  logic             winner;
  logic             win_op;
  logic [width-1:0] win_a, win_b;

  logic             reuse_hit;
  logic [width-1:0] reuse_r1, reuse_r2;

  // Round-robin pick: a lone requester wins, otherwise the pointer decides
  always_comb begin
    any_req = Req0_i | Req1_i;
    if (Req0_i && Req1_i) winner = prio_q;
    else                  winner = Req1_i;
    win_op = winner ? Op1_i : Op0_i;
    win_a  = winner ? A1_i  : A0_i;
    win_b  = winner ? B1_i  : B0_i;
  end

`ifdef MCYCLE_REUSE_EN
  logic             rv_q;
  logic             rop_q;
  logic [width-1:0] ra_q, rb_q, rr1_q, rr2_q;

  // Remember the last computation so an identical request can bypass the unit
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rv_q  <= 1'b0;
      rop_q <= 1'b0;
      ra_q  <= '0;
      rb_q  <= '0;
      rr1_q <= '0;
      rr2_q <= '0;
    end else if (state_q == WAIT && !UnitBusy_i) begin
      rv_q  <= 1'b1;
      rop_q <= op_q;
      ra_q  <= opa_q;
      rb_q  <= opb_q;
      rr1_q <= UnitResult1_i;
      rr2_q <= UnitResult2_i;
    end
  end

  assign reuse_hit = rv_q && (rop_q == win_op) && (ra_q == win_a) && (rb_q == win_b);
  assign reuse_r1  = rr1_q;
  assign reuse_r2  = rr2_q;
`else
  assign reuse_hit = 1'b0;
  assign reuse_r1  = '0;
  assign reuse_r2  = '0;
`endif

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; UnitBusy is only looked at in WAIT since it may rise with Start
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = reuse_hit ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (!UnitBusy_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, grant pointer and latched operands
  always_comb begin
    grant_d = grant_q;
    prio_d  = prio_q;
    start_d = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          prio_d  = ~winner;
          if (reuse_hit) begin
            res1_d = reuse_r1;
            res2_d = reuse_r2;
            ack0_d = ~winner;
            ack1_d = winner;
          end else begin
            start_d = 1'b1;
            op_d    = win_op;
            opa_d   = win_a;
            opb_d   = win_b;
          end
        end
      end
      WAIT: begin
        if (!UnitBusy_i) begin
          res1_d = UnitResult1_i;
          res2_d = UnitResult2_i;
          ack0_d = ~grant_q;
          ack1_d = grant_q;
        end
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      op_q    <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      grant_q <= grant_d;
      prio_q  <= prio_d;
      start_q <= start_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

  assign ArbBusy_o  = (state_q != IDLE);
  assign Grant_o    = grant_q;
  assign Start_o    = start_q;
  assign Ack0_o     = ack0_q;
  assign Ack1_o     = ack1_q;
  assign MCycleOp_o = op_q;
  assign Operand1_o = opa_q;
  assign Operand2_o = opb_q;
  assign Result1_o  = res1_q;
  assign Result2_o  = res2_q;

endmodule

// File: doc/mcycle_arbiter.md
# mcycle_arbiter

Shares one multi-cycle multiply/divide unit between two requesters (e.g. two issue ports) with round-robin arbitration. It latches the winning requester's operands and op, pulses Start to the unit, and waits for the unit's Busy to fall. It then captures the unit's two result words and returns them to the owner with a one-cycle Ack. It sits between the execute stage(s) and the MCycle unit.

## Interface
- width, 32, operand and result word width
- CLK  in  1  clock, rising edge
- Reset  in  1  reset; asynchronous, active-high
- Req0 / Req1  in  1  request valid; held high until the matching Ack
- Op0 / Op1  in  1  requested op: 0 = multiply, 1 = divide
- A0, B0 / A1, B1  in  width  operands; stable while Req is high
- Ack0 / Ack1  out  1  one-cycle pulse; Result1/Result2 valid that cycle
- Result1  out  width  product low word / quotient
- Result2  out  width  product high word / remainder
- Grant  out  1  index of the current or last owner
- ArbBusy  out  1  high whenever the state is not IDLE
- Start  out  1  one-cycle start pulse to the unit
- MCycleOp  out  1  latched op to the unit
- Operand1 / Operand2  out  width  latched operands to the unit
- UnitBusy  in  1  unit Busy; may rise combinationally with Start
- UnitResult1 / UnitResult2  in  width  unit result words

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except ArbBusy, which is decoded from state.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that requester.
- IDLE, both requesting: grant the requester selected by pointer Prio.
- On a grant:
  - Grant <= winner.
  - MCycleOp/Operand1/Operand2 <= winner's Op/A/B.
  - Prio <= ~winner.
  - Next state is ISSUE.
- ISSUE: Start = 1 for exactly this cycle; next state is WAIT.
- WAIT: Start = 0.
  - UnitBusy = 0: Result1/Result2 <= UnitResult1/UnitResult2; next state is RESP.
  - Otherwise stay in WAIT; there is no timeout.
- RESP: Ack[Grant] = 1 for one cycle; next state is IDLE.
- Requester handshake: deassert Req on the edge ending its Ack cycle.
- A requester that keeps Req high after Ack is treated as a new request.
- A request arriving while ArbBusy = 1 waits; it is never dropped.
- Result1/Result2 hold their value until the next capture.
- Operand1/Operand2/MCycleOp hold their value until the next grant.

## Timing
- Reset values:
  - state IDLE; Start, Ack0, Ack1, Grant, Prio, MCycleOp = 0.
  - Operand1, Operand2, Result1, Result2 = 0.
  - Reuse valid flag cleared.
- Reset mid-operation: return to IDLE at once, with no Ack and no Start. The unit is reset by the same Reset.
- Latency, with Req first seen in IDLE in cycle 0:
  - Start is high in cycle 1.
  - WAIT begins in cycle 2.
  - With UnitBusy first low in cycle 2+N, Ack is high in cycle 3+N.
- UnitBusy is ignored in ISSUE, because it may rise combinationally with Start.
- Back-to-back service: the earliest next Start is 2 cycles after an Ack (RESP -> IDLE -> ISSUE).
- Fairness: with both Req held continuously, grants alternate 0, 1, 0, 1 …
- Starvation is impossible: worst-case wait is one full service of the other requester.

## Configuration
- Macro MCYCLE_REUSE_EN.
- Defined:
  - On each WAIT capture, store op, operands and results, and set the valid flag.
  - On a grant in IDLE where valid = 1 and the winner's Op/A/B exactly match the stored values:
    - go directly to RESP with the stored results, and issue no Start;
    - Ack arrives in cycle 1 after the request.
  - Operand1/Operand2/MCycleOp are not updated on a reuse hit.
  - Prio still toggles on a reuse hit.
- Undefined: no storage, and every grant issues Start.

## Test plan
- Reset mid-WAIT (Req0 with A0=7, B0=6, Op0=0) -> Start, Ack0, Ack1, Grant, Result1, Result2 all 0 next cycle, state IDLE, no Ack afterwards until a new request.
- Single multiply, Req0, A0=7, B0=6, Op0=0, unit model held Busy for 32 cycles -> one Start pulse, and Ack0 with Result1=42, Result2=0 exactly 34 cycles after Start. Ack1 never asserts.
- Single divide, Req1, A1=100, B1=7, Op1=1 -> Ack1 with Result1=14, Result2=2, and Grant=1 during service.
- Simultaneous Req0/Req1 held for 4 services after reset -> grant order 0, 1, 0, 1, with exactly 4 Start pulses and 4 Acks.
- Req1 asserted while servicing Req0 -> Req1 starts 2 cycles after Ack0, and its operands are unchanged at issue.
- With MCYCLE_REUSE_EN defined, repeat Req0 7×6 after it completes -> Ack0 one cycle after the request, Result1=42, no Start. Without the macro -> full re-issue.
